// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain readback path.
// Holds the FSM state type and the widths shared with the head-side loader.
package ccff_pkg;

  localparam int CCFF_WORD_W = 32;
  localparam int CCFF_LEN_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

endpackage

// File: rtl/ccff_out_reg.sv
// Single-entry valid/ready holding register with overflow detection.
// Ports: load_i/data_i/last_i load a word, ready_i drains it,
//   clr_i clears the sticky overflow, drop_o flags a word lost this cycle.
module ccff_out_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         clr_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         last_o,
  output logic         overflow_o,
  output logic         drop_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         ovf_q, ovf_d;
  logic         hs, accept;

  // A load is taken when the slot is empty or being emptied this cycle.
  always_comb begin
    hs      = valid_q & ready_i;
    accept  = load_i & (~valid_q | ready_i);
    drop_o  = load_i & valid_q & ~ready_i;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (accept) begin
      data_d  = data_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (hs) begin
      valid_d = 1'b0;
    end
    if (clr_i) ovf_d = 1'b0;
    else if (drop_o) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ccff_readback.sv
// Captures the serial chain tail and packs it MSB-first into words.
// Ports: start_i/bit_count_i launch a capture, shift_en_i/ccff_tail_i
//   feed bits, word_o/word_valid_o/word_ready_i/last_o drain words,
//   busy_o/done_o/overflow_o report status.
module ccff_readback
  import ccff_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W,
  parameter int LEN_W  = CCFF_LEN_W
) (
  input  logic              tck_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  bit_count_i,
  input  logic              shift_en_i,
  input  logic              ccff_tail_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int IDX_W = $clog2(WORD_W) + 1;

  ccff_state_e       state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              drop_last_q, drop_last_d;

  logic              fire;
  logic              final_bit;
  logic              word_done;
  logic              start_ok;
  logic              dropped;
  logic              hs;
  logic [WORD_W-1:0] sh_next;
  logic [WORD_W-1:0] word_al;
  logic [IDX_W-1:0]  idx_inc;
  logic [IDX_W-1:0]  pad;

  always_comb begin
    fire      = (state_q == ST_SHIFT) & shift_en_i;
    start_ok  = (state_q == ST_IDLE) & start_i;
    sh_next   = {shreg_q[WORD_W-2:0], ccff_tail_i};
    idx_inc   = idx_q + 1'b1;
    final_bit = fire & (rem_q == LEN_W'(1));
    word_done = fire & ((idx_inc == IDX_W'(WORD_W)) | final_bit);
    // A short final word is left-aligned; stale high bits shift out.
    pad       = IDX_W'(WORD_W) - idx_inc;
    word_al   = sh_next << pad;
    hs        = word_valid_o & word_ready_i;
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    drop_last_d = drop_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_d       = '0;
          drop_last_d = 1'b0;
          if (bit_count_i != '0) begin
            rem_d   = bit_count_i;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (shift_en_i) begin
          shreg_d = sh_next;
          rem_d   = rem_q - 1'b1;
          idx_d   = word_done ? '0 : idx_inc;
          if (final_bit) begin
            drop_last_d = dropped;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // A dropped final word will never be handshaken.
        if (drop_last_q | hs) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      drop_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      drop_last_q <= drop_last_d;
    end
  end

  ccff_out_reg #(
    .W(WORD_W)
  ) u_out (
    .clk_i     (tck_i),
    .rst_i     (rst_i),
    .load_i    (word_done),
    .data_i    (word_al),
    .last_i    (final_bit),
    .clr_i     (start_ok),
    .ready_i   (word_ready_i),
    .data_o    (word_o),
    .valid_o   (word_valid_o),
    .last_o    (last_o),
    .overflow_o(overflow_o),
    .drop_o    (dropped)
  );

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_ccff_readback.sv
// Directed self-checking bench for ccff_readback.
// Each scenario task drives stimulus and checks results inline.
module tb_ccff_readback;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] bit_count;
  logic        shift_en;
  logic        tail;
  logic [31:0] word;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;
  logic        done;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] wq[$];
  logic        lq[$];

  ccff_readback #(.WORD_W(32), .LEN_W(20)) dut (
    .tck_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .bit_count_i (bit_count),
    .shift_en_i  (shift_en),
    .ccff_tail_i (tail),
    .word_o      (word),
    .word_valid_o(valid),
    .word_ready_i(ready),
    .last_o      (last),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+2, so the negedge sees what the next edge sees.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      wq.push_back(word);
      lq.push_back(last);
    end
    if (!rst && done) done_cnt++;
  end

  task automatic do_start(input logic [19:0] n);
    @(posedge clk); #2;
    start = 1'b1;
    bit_count = n;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      shift_en = 1'b1;
      tail = d[31-i];
    end
  endtask

  task automatic send_end();
    @(posedge clk); #2;
    shift_en = 1'b0;
  endtask

  task automatic wait_done(input int base, input string nm);
    int k;
    k = 0;
    while (done_cnt <= base && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt <= base) begin
      errors++;
      $display("FAIL %s_timeout: done_cnt=%0d required>%0d", nm, done_cnt, base);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; bit_count = 0; shift_en = 0; tail = 0; ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({word, valid, last, busy, done, ovf} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b%b required 0", word, valid, last, busy, done, ovf);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_exact();
    int base;
    base = done_cnt;
    wq.delete(); lq.delete();
    ready = 1'b1;
    do_start(20'd64);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL exact_busy: got %b required 1", busy);
    end
    send(32'hDEADBEEF, 32);
    send(32'h12345678, 32);
    send_end();
    wait_done(base, "exact");
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL exact_count: got %0d words required 2", wq.size());
    end else begin
      checks++;
      if (wq[0] !== 32'hDEADBEEF || lq[0] !== 1'b0) begin
        errors++;
        $display("FAIL exact_w0: got %h last %b required deadbeef last 0", wq[0], lq[0]);
      end
      checks++;
      if (wq[1] !== 32'h12345678 || lq[1] !== 1'b1) begin
        errors++;
        $display("FAIL exact_w1: got %h last %b required 12345678 last 1", wq[1], lq[1]);
      end
    end
    checks++;
    if (done_cnt - base != 1 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL exact_status: done pulses %0d ovf %b busy %b required 1 0 0", done_cnt - base, ovf, busy);
    end
  endtask

  task automatic test_partial();
    int base;
    base = done_cnt;
    wq.delete(); lq.delete();
    ready = 1'b1;
    do_start(20'd40);
    send(32'hA5A5A5A5, 32);
    send(32'hFF000000, 8);
    send_end();
    wait_done(base, "partial");
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL partial_count: got %0d words required 2", wq.size());
    end else begin
      checks++;
      if (wq[0] !== 32'hA5A5A5A5 || lq[0] !== 1'b0) begin
        errors++;
        $display("FAIL partial_w0: got %h last %b required a5a5a5a5 last 0", wq[0], lq[0]);
      end
      checks++;
      if (wq[1] !== 32'hFF000000 || lq[1] !== 1'b1) begin
        errors++;
        $display("FAIL partial_w1: got %h last %b required ff000000 last 1", wq[1], lq[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = done_cnt;
    wq.delete(); lq.delete();
    ready = 1'b0;
    do_start(20'd96);
    send(32'h11111111, 32);
    send(32'h22222222, 32);
    send(32'h33333333, 32);
    send_end();
    wait_done(base, "bp");
    checks++;
    if (ovf !== 1'b1 || valid !== 1'b1 || word !== 32'h11111111 || last !== 1'b0) begin
      errors++;
      $display("FAIL bp_held: ovf %b valid %b word %h last %b required 1 1 11111111 0", ovf, valid, word, last);
    end
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL bp_noaccept: got %0d words required 0", wq.size());
    end
    @(posedge clk); #2;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wq.size() != 1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %0d words valid %b required 1 word valid 0", wq.size(), valid);
    end else begin
      checks++;
      if (wq[0] !== 32'h11111111) begin
        errors++;
        $display("FAIL bp_word: got %h required 11111111", wq[0]);
      end
    end
    checks++;
    if (done_cnt - base != 1) begin
      errors++;
      $display("FAIL bp_done: got %0d pulses required 1", done_cnt - base);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    base = done_cnt;
    wq.delete(); lq.delete();
    ready = 1'b0;
    do_start(20'd64);
    send(32'hAAAA5555, 32);
    send(32'h0F0F3C3C, 31);
    #1;
    checks++;
    if (valid !== 1'b1 || word !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL sim_stable: valid %b word %h required 1 aaaa5555", valid, word);
    end
    @(posedge clk); #2;
    tail = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b1 || word !== 32'h0F0F3C3C || last !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sim_reload: valid %b word %h last %b ovf %b required 1 0f0f3c3c 1 0", valid, word, last, ovf);
    end
    #1;
    shift_en = 1'b0;
    wait_done(base, "sim");
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL sim_count: got %0d words required 2", wq.size());
    end else begin
      checks++;
      if (wq[0] !== 32'hAAAA5555 || wq[1] !== 32'h0F0F3C3C) begin
        errors++;
        $display("FAIL sim_words: got %h %h required aaaa5555 0f0f3c3c", wq[0], wq[1]);
      end
    end
  endtask

  task automatic test_zero_len();
    int base;
    base = done_cnt;
    wq.delete(); lq.delete();
    ready = 1'b1;
    do_start(20'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: done %b busy %b required 1 1", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_end: done %b busy %b valid %b required 0 0 0", done, busy, valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wq.size() != 0 || done_cnt - base != 1) begin
      errors++;
      $display("FAIL zero_words: got %0d words %0d pulses required 0 1", wq.size(), done_cnt - base);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    ready = 1'b1;
    do_start(20'd32);
    send(32'hFFFF8000, 17);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mrst_busy: got %b required 1", busy);
    end
    rst = 1'b1;
    shift_en = 1'b0;
    #1;
    checks++;
    if ({word, valid, last, busy, done, ovf} !== 37'd0) begin
      errors++;
      $display("FAIL mrst_outputs: got %h/%b%b%b%b%b required 0", word, valid, last, busy, done, ovf);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    base = done_cnt;
    wq.delete(); lq.delete();
    do_start(20'd32);
    send(32'hCAFEF00D, 32);
    send_end();
    wait_done(base, "mrst");
    checks++;
    if (wq.size() != 1) begin
      errors++;
      $display("FAIL mrst_count: got %0d words required 1", wq.size());
    end else begin
      checks++;
      if (wq[0] !== 32'hCAFEF00D || lq[0] !== 1'b1) begin
        errors++;
        $display("FAIL mrst_word: got %h last %b required cafef00d last 1", wq[0], lq[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_partial();
    test_backpressure();
    test_simultaneous();
    test_zero_len();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
